// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=7 rate-1/2 convolutional code (encoder and decoder).
package viterbi_pkg;

  localparam int unsigned K_DEFAULT  = 7;
  localparam int unsigned NUM_STATES = 2 ** (K_DEFAULT - 1);

  // MSB of each generator taps the current input bit.
  localparam logic [K_DEFAULT-1:0] G0_DEFAULT = 7'o171;
  localparam logic [K_DEFAULT-1:0] G1_DEFAULT = 7'o133;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StTail
  } enc_state_e;

  typedef logic [1:0] code_pair_t;

endpackage

// File: rtl/conv_branch_out.sv
// Code pair for one trellis branch: parity of each generator against the window.
module conv_branch_out
  import viterbi_pkg::*;
#(
  parameter int unsigned K = K_DEFAULT
) (
  input  logic [K-1:0] w,
  input  logic [K-1:0] g0,
  input  logic [K-1:0] g1,
  output code_pair_t   pair
);

  assign pair = {^(g1 & w), ^(g0 & w)};

endmodule

// File: rtl/conv_encoder_k7.sv
// Framed rate-1/2 convolutional encoder with optional zero tail and a single output register.
module conv_encoder_k7
  import viterbi_pkg::*;
#(
  parameter int unsigned     K       = K_DEFAULT,
  parameter logic [K-1:0]    G0      = G0_DEFAULT,
  parameter logic [K-1:0]    G1      = G1_DEFAULT,
  parameter bit              TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output code_pair_t tx_pair,
  output logic       out_last
);

  localparam int unsigned           TailCntW = $clog2(K);
  localparam logic [TailCntW-1:0]   TailLast = TailCntW'(K - 2);

  enc_state_e            state_q, state_d;
  logic [K-2:0]          sr_q, sr_d;
  logic [TailCntW-1:0]   tail_cnt_q, tail_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  code_pair_t            tx_pair_q, tx_pair_d;
  code_pair_t            pair;
  logic                  advance, accept, b;
  logic [K-1:0]          w;

  // The output register may load whenever it is empty or being drained this cycle.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && (state_q != StTail);
  assign accept   = in_valid && in_ready;

  assign b = (state_q == StTail) ? 1'b0 : in_bit;
  assign w = {b, sr_q};

  conv_branch_out #(
    .K(K)
  ) u_branch (
    .w   (w),
    .g0  (G0),
    .g1  (G1),
    .pair(pair)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    tail_cnt_d  = tail_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    tx_pair_d   = tx_pair_q;

    unique case (state_q)
      StIdle, StData: begin
        if (accept) begin
          out_valid_d = 1'b1;
          tx_pair_d   = pair;
          sr_d        = w[K-1:1];
          out_last_d  = 1'b0;
          state_d     = StData;
          if (in_last) begin
            if (TAIL_EN) begin
              state_d = StTail;
            end else begin
              // Without a tail the memory is flushed so the next frame starts in state 0.
              state_d    = StIdle;
              sr_d       = '0;
              out_last_d = 1'b1;
            end
          end
        end else if (advance) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      StTail: begin
        if (advance) begin
          out_valid_d = 1'b1;
          tx_pair_d   = pair;
          sr_d        = w[K-1:1];
          if (tail_cnt_q == TailLast) begin
            out_last_d = 1'b1;
            tail_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            out_last_d = 1'b0;
            tail_cnt_d = tail_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      tail_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      tx_pair_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      tx_pair_q   <= tx_pair_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign tx_pair   = tx_pair_q;

endmodule
